// File: rtl/fetch_stage_if.sv
// Handshake and data signals between the fetch stage, instruction memory,
// execute-stage redirects and the decode-side IF/ID register.
interface fetch_stage_if;
    logic [1:0]  PC_SOURCE;
    logic [31:0] JALR;
    logic [31:0] BRANCH;
    logic [31:0] JAL;
    logic        STALL;
    logic        IMEM_REQ;
    logic [31:0] IMEM_ADDR;
    logic        IMEM_GNT;
    logic        IMEM_RVALID;
    logic [31:0] IMEM_RDATA;
    logic [31:0] IF_IR;
    logic [31:0] IF_PC;
    logic [31:0] IF_PC_PLUS4;
    logic        IF_VALID;
    logic        ERR_PC;

    modport master (
        input  PC_SOURCE, JALR, BRANCH, JAL, STALL,
        input  IMEM_GNT, IMEM_RVALID, IMEM_RDATA,
        output IMEM_REQ, IMEM_ADDR,
        output IF_IR, IF_PC, IF_PC_PLUS4, IF_VALID, ERR_PC
    );

    modport slave (
        output PC_SOURCE, JALR, BRANCH, JAL, STALL,
        output IMEM_GNT, IMEM_RVALID, IMEM_RDATA,
        input  IMEM_REQ, IMEM_ADDR,
        input  IF_IR, IF_PC, IF_PC_PLUS4, IF_VALID, ERR_PC
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single outstanding imem read, IF/ID register with a
// one-entry skid buffer, and execute-stage redirects that squash in-flight work.
//
// state  | meaning
// IDLE   | just out of reset, no request issued yet
// REQ    | requesting imem at PC, waiting for grant
// WAIT   | granted, waiting for read data
// HOLD   | response parked in skid buffer while decode stalls
// DROP   | redirected while a read is in flight; its data will be discarded
module fetch_stage #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic           IF_CLK,
    input logic           IF_RST,
    fetch_stage_if.master bus
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [31:0] skid_ir;
    logic [31:0] skid_pc;
    logic [31:0] if_ir;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        if_valid;
    logic        err_pc;
    logic        redirect;
    logic [31:0] sel_target;
    logic [31:0] target;

    always_comb begin
        sel_target = 32'h0;
        case (bus.PC_SOURCE)
            2'd1:    sel_target = bus.JALR;
            2'd2:    sel_target = bus.BRANCH;
            2'd3:    sel_target = bus.JAL;
            default: sel_target = 32'h0;
        endcase
    end

    assign redirect = (bus.PC_SOURCE != 2'd0);
    assign target   = {sel_target[31:2], 2'b00};

    always_ff @(posedge IF_CLK or posedge IF_RST) begin
        if (IF_RST) begin
            state       <= S_IDLE;
            pc          <= RESET_VEC;
            req_pc      <= 32'h0;
            skid_ir     <= 32'h0;
            skid_pc     <= 32'h0;
            if_ir       <= NOP_INSTR;
            if_pc       <= 32'h0;
            if_pc_plus4 <= 32'h0;
            if_valid    <= 1'b0;
            err_pc      <= 1'b0;
        end else begin
            err_pc <= redirect && (sel_target[1:0] != 2'b00);

            // Decode takes the current entry; later assignments may refill it.
            if (if_valid && !bus.STALL) begin
                if_valid <= 1'b0;
                if_ir    <= NOP_INSTR;
            end

            case (state)
                S_IDLE: state <= S_REQ;
                S_REQ: begin
                    if (bus.IMEM_GNT) begin
                        req_pc <= pc;
                        pc     <= pc + 32'd4;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.IMEM_RVALID) begin
                        if (!if_valid || !bus.STALL) begin
                            if_ir       <= bus.IMEM_RDATA;
                            if_pc       <= req_pc;
                            if_pc_plus4 <= req_pc + 32'd4;
                            if_valid    <= 1'b1;
                            state       <= S_REQ;
                        end else begin
                            skid_ir <= bus.IMEM_RDATA;
                            skid_pc <= req_pc;
                            state   <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!bus.STALL) begin
                        if_ir       <= skid_ir;
                        if_pc       <= skid_pc;
                        if_pc_plus4 <= skid_pc + 32'd4;
                        if_valid    <= 1'b1;
                        state       <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (bus.IMEM_RVALID)
                        state <= S_REQ;
                end
                default: state <= S_IDLE;
            endcase

            // Redirect wins over everything above, including a stalled decode.
            if (redirect) begin
                pc       <= target;
                if_valid <= 1'b0;
                if_ir    <= NOP_INSTR;
                case (state)
                    S_REQ:   state <= bus.IMEM_GNT ? S_DROP : S_REQ;
                    S_WAIT:  state <= bus.IMEM_RVALID ? S_REQ : S_DROP;
                    S_HOLD:  state <= S_REQ;
                    default: ;
                endcase
            end
        end
    end

    assign bus.IMEM_REQ    = (state == S_REQ);
    assign bus.IMEM_ADDR   = pc;
    assign bus.IF_IR       = if_ir;
    assign bus.IF_PC       = if_pc;
    assign bus.IF_PC_PLUS4 = if_pc_plus4;
    assign bus.IF_VALID    = if_valid;
    assign bus.ERR_PC      = err_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: inputs driven and outputs sampled on the
// falling clock edge, expected values hand-computed.
module tb_fetch_stage;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    fetch_stage_if bus();

    fetch_stage #(
        .RESET_VEC(32'h0000_0000),
        .NOP_INSTR(32'h0000_0013)
    ) dut (
        .IF_CLK(clk),
        .IF_RST(rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        bus.PC_SOURCE   = 2'd0;
        bus.JALR        = 32'h0;
        bus.BRANCH      = 32'h0;
        bus.JAL         = 32'h0;
        bus.STALL       = 1'b0;
        bus.IMEM_GNT    = 1'b0;
        bus.IMEM_RVALID = 1'b0;
        bus.IMEM_RDATA  = 32'h0;
        tick();
        tick();

        check_val("rst_valid", {31'h0, bus.IF_VALID}, 32'h0);
        check_val("rst_ir",    bus.IF_IR, 32'h0000_0013);
        check_val("rst_pc",    bus.IF_PC, 32'h0);
        check_val("rst_pc4",   bus.IF_PC_PLUS4, 32'h0);
        check_val("rst_req",   {31'h0, bus.IMEM_REQ}, 32'h0);
        check_val("rst_err",   {31'h0, bus.ERR_PC}, 32'h0);
        check_val("rst_addr",  bus.IMEM_ADDR, 32'h0);
        rst = 1'b0;
        tick();

        // First fetch, minimum latency
        check_val("idle_to_req", {31'h0, bus.IMEM_REQ}, 32'h1);
        check_val("first_addr", bus.IMEM_ADDR, 32'h0);
        bus.IMEM_GNT = 1'b1;
        tick();
        check_val("wait_no_req", {31'h0, bus.IMEM_REQ}, 32'h0);
        bus.IMEM_GNT    = 1'b0;
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'h0050_0093;
        tick();
        bus.IMEM_RVALID = 1'b0;
        check_val("f0_valid", {31'h0, bus.IF_VALID}, 32'h1);
        check_val("f0_ir",    bus.IF_IR, 32'h0050_0093);
        check_val("f0_pc",    bus.IF_PC, 32'h0);
        check_val("f0_pc4",   bus.IF_PC_PLUS4, 32'h4);
        check_val("f0_req",   {31'h0, bus.IMEM_REQ}, 32'h1);
        check_val("f0_next",  bus.IMEM_ADDR, 32'h4);

        // Stall with a response arriving -> skid buffer / HOLD
        bus.STALL    = 1'b1;
        bus.IMEM_GNT = 1'b1;
        tick();
        bus.IMEM_GNT    = 1'b0;
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'hAAAA_0013;
        tick();
        bus.IMEM_RVALID = 1'b0;
        check_val("hold_req",   {31'h0, bus.IMEM_REQ}, 32'h0);
        check_val("hold_pc",    bus.IF_PC, 32'h0);
        check_val("hold_ir",    bus.IF_IR, 32'h0050_0093);
        check_val("hold_valid", {31'h0, bus.IF_VALID}, 32'h1);
        tick();
        check_val("hold2_req", {31'h0, bus.IMEM_REQ}, 32'h0);
        check_val("hold2_pc",  bus.IF_PC, 32'h0);
        bus.STALL = 1'b0;
        tick();
        check_val("unhold_pc",    bus.IF_PC, 32'h4);
        check_val("unhold_ir",    bus.IF_IR, 32'hAAAA_0013);
        check_val("unhold_pc4",   bus.IF_PC_PLUS4, 32'h8);
        check_val("unhold_valid", {31'h0, bus.IF_VALID}, 32'h1);
        check_val("unhold_req",   {31'h0, bus.IMEM_REQ}, 32'h1);
        check_val("unhold_addr",  bus.IMEM_ADDR, 32'h8);

        // JAL redirect while waiting; response arrives two cycles later
        bus.IMEM_GNT = 1'b1;
        tick();
        check_val("consumed_valid", {31'h0, bus.IF_VALID}, 32'h0);
        check_val("consumed_ir",    bus.IF_IR, 32'h0000_0013);
        bus.IMEM_GNT  = 1'b0;
        bus.PC_SOURCE = 2'd3;
        bus.JAL       = 32'h0000_0100;
        tick();
        bus.PC_SOURCE = 2'd0;
        check_val("jal_valid", {31'h0, bus.IF_VALID}, 32'h0);
        check_val("jal_req",   {31'h0, bus.IMEM_REQ}, 32'h0);
        check_val("jal_err",   {31'h0, bus.ERR_PC}, 32'h0);
        tick();
        check_val("drop_req", {31'h0, bus.IMEM_REQ}, 32'h0);
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'hDEAD_0013;
        tick();
        bus.IMEM_RVALID = 1'b0;
        check_val("drop_valid", {31'h0, bus.IF_VALID}, 32'h0);
        check_val("drop_ir",    bus.IF_IR, 32'h0000_0013);
        check_val("jal_req2",   {31'h0, bus.IMEM_REQ}, 32'h1);
        check_val("jal_addr",   bus.IMEM_ADDR, 32'h100);
        bus.IMEM_GNT = 1'b1;
        tick();
        bus.IMEM_GNT    = 1'b0;
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'h1110_0093;
        tick();
        bus.IMEM_RVALID = 1'b0;
        check_val("jal_f_pc",    bus.IF_PC, 32'h100);
        check_val("jal_f_ir",    bus.IF_IR, 32'h1110_0093);
        check_val("jal_f_valid", {31'h0, bus.IF_VALID}, 32'h1);
        check_val("jal_f_next",  bus.IMEM_ADDR, 32'h104);

        // JALR redirect in REQ without grant, then BRANCH on the grant cycle
        bus.PC_SOURCE = 2'd1;
        bus.JALR      = 32'h0000_0020;
        tick();
        bus.PC_SOURCE = 2'd0;
        check_val("r20_addr",  bus.IMEM_ADDR, 32'h20);
        check_val("r20_req",   {31'h0, bus.IMEM_REQ}, 32'h1);
        check_val("r20_valid", {31'h0, bus.IF_VALID}, 32'h0);
        bus.IMEM_GNT  = 1'b1;
        bus.PC_SOURCE = 2'd2;
        bus.BRANCH    = 32'h0000_0040;
        tick();
        bus.IMEM_GNT  = 1'b0;
        bus.PC_SOURCE = 2'd0;
        check_val("br_drop_req", {31'h0, bus.IMEM_REQ}, 32'h0);
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'hBAD0_0013;
        tick();
        bus.IMEM_RVALID = 1'b0;
        check_val("br_valid", {31'h0, bus.IF_VALID}, 32'h0);
        check_val("br_req",   {31'h0, bus.IMEM_REQ}, 32'h1);
        check_val("br_addr",  bus.IMEM_ADDR, 32'h40);

        // Misaligned JALR target
        bus.PC_SOURCE = 2'd1;
        bus.JALR      = 32'h0000_0207;
        tick();
        bus.PC_SOURCE = 2'd0;
        check_val("err_pulse", {31'h0, bus.ERR_PC}, 32'h1);
        check_val("err_addr",  bus.IMEM_ADDR, 32'h204);
        tick();
        check_val("err_clear", {31'h0, bus.ERR_PC}, 32'h0);

        // PC wrap at the top of the address space
        bus.PC_SOURCE = 2'd3;
        bus.JAL       = 32'hFFFF_FFFC;
        tick();
        bus.PC_SOURCE = 2'd0;
        check_val("top_addr", bus.IMEM_ADDR, 32'hFFFF_FFFC);
        bus.IMEM_GNT = 1'b1;
        tick();
        bus.IMEM_GNT    = 1'b0;
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'h0000_0073;
        tick();
        bus.IMEM_RVALID = 1'b0;
        check_val("wrap_pc",   bus.IF_PC, 32'hFFFF_FFFC);
        check_val("wrap_pc4",  bus.IF_PC_PLUS4, 32'h0);
        check_val("wrap_ir",   bus.IF_IR, 32'h0000_0073);
        check_val("wrap_next", bus.IMEM_ADDR, 32'h0);

        // Redirect coinciding with read data: data discarded, fetch restarts
        bus.IMEM_GNT = 1'b1;
        tick();
        bus.IMEM_GNT    = 1'b0;
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'h5555_0013;
        bus.PC_SOURCE   = 2'd3;
        bus.JAL         = 32'h0000_0300;
        tick();
        bus.IMEM_RVALID = 1'b0;
        bus.PC_SOURCE   = 2'd0;
        check_val("wrd_valid", {31'h0, bus.IF_VALID}, 32'h0);
        check_val("wrd_req",   {31'h0, bus.IMEM_REQ}, 32'h1);
        check_val("wrd_addr",  bus.IMEM_ADDR, 32'h300);

        // Reset mid-transaction; late response after release is ignored
        bus.IMEM_GNT = 1'b1;
        tick();
        bus.IMEM_GNT = 1'b0;
        rst = 1'b1;
        #1;
        check_val("mrst_req",   {31'h0, bus.IMEM_REQ}, 32'h0);
        check_val("mrst_addr",  bus.IMEM_ADDR, 32'h0);
        check_val("mrst_valid", {31'h0, bus.IF_VALID}, 32'h0);
        tick();
        rst = 1'b0;
        bus.IMEM_RVALID = 1'b1;
        bus.IMEM_RDATA  = 32'h7777_0013;
        tick();
        bus.IMEM_RVALID = 1'b0;
        check_val("late_valid", {31'h0, bus.IF_VALID}, 32'h0);
        check_val("late_ir",    bus.IF_IR, 32'h0000_0013);
        check_val("late_req",   {31'h0, bus.IMEM_REQ}, 32'h1);
        check_val("late_addr",  bus.IMEM_ADDR, 32'h0);
        tick();
        check_val("late_valid2", {31'h0, bus.IF_VALID}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_VEC, 32'h00000000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, 32'h00000013, IF_IR value while no valid instruction is held.
REQ-003 IF_CLK  input  1  single clock; all state updates on rising edge.
REQ-004 IF_RST  input  1  reset, asynchronous, active-high.
REQ-005 PC_SOURCE  input  2  redirect select from execute: 0=PC+4 (no redirect), 1=JALR, 2=BRANCH, 3=JAL.
REQ-006 JALR, BRANCH, JAL  input  32 each  redirect targets, sampled only in the cycle PC_SOURCE selects them.
REQ-007 STALL  input  1  decode cannot accept; holds the IF/ID output register.
REQ-008 IMEM_REQ  output  1  read request; IMEM_ADDR  output  32  request address.
REQ-009 IMEM_GNT  input  1  request accepted this cycle (IMEM_REQ & IMEM_GNT).
REQ-010 IMEM_RVALID  input  1  read data valid, at least 1 cycle after grant; IMEM_RDATA  input  32.
REQ-011 IF_IR, IF_PC, IF_PC_PLUS4  output  32 each  IF/ID register: instruction, its address, address+4.
REQ-012 IF_VALID  output  1  IF/ID register holds a valid instruction.
REQ-013 ERR_PC  output  1  one-cycle pulse on a misaligned redirect target.

Function
REQ-014 FSM states: IDLE, REQ, WAIT, HOLD, DROP; at most one memory request outstanding.
REQ-015 IDLE: entered only by reset; unconditionally goes to REQ on the next edge.
REQ-016 REQ: IMEM_REQ=1, IMEM_ADDR=PC; on grant, REQ_PC<=PC, PC<=PC+4 (mod 2^32, wraps 0xFFFFFFFC->0), go to WAIT; without grant, stay.
REQ-017 IMEM_REQ SHALL be 0 in every state other than REQ.
REQ-018 WAIT, on RVALID with IF/ID free (IF_VALID=0, or STALL=0): IF/ID<=(RDATA, REQ_PC, REQ_PC+4), IF_VALID<=1, go to REQ.
REQ-019 WAIT, on RVALID with IF/ID occupied and STALL=1: RDATA/REQ_PC captured into a one-entry skid buffer, go to HOLD.
REQ-020 IF/ID is consumed on any edge where IF_VALID=1 and STALL=0; if nothing replaces it, IF_VALID<=0 and IF_IR<=NOP_INSTR.
REQ-021 HOLD: no requests; when STALL=0, skid buffer moves into IF/ID (IF_VALID stays 1) and the FSM goes to REQ.
REQ-022 Redirect = PC_SOURCE!=0 in a cycle; target = mux(PC_SOURCE) with bits[1:0] forced to 0; PC<=target.
REQ-023 Redirect SHALL clear IF_VALID (IF_IR<=NOP_INSTR) and empty the skid buffer at that edge, overriding STALL.
REQ-024 Redirect transitions: REQ without grant->REQ; REQ with grant same cycle->DROP (granted old address, PC<=target not PC+4); WAIT without RVALID->DROP; WAIT with RVALID->REQ, data discarded; HOLD->REQ; DROP->DROP.
REQ-025 DROP: on RVALID, discard data, go to REQ; IF_VALID stays 0.
REQ-026 ERR_PC=1 for the one cycle after a redirect whose selected target has bits[1:0]!=0; otherwise 0.
REQ-027 Minimum latency: grant in cycle N, RVALID in N+1 -> IF_VALID=1 at edge ending N+1; peak throughput one instruction per 2 cycles.

Reset
REQ-028 While IF_RST=1: PC=RESET_VEC, state=IDLE, IF_VALID=0, IF_IR=NOP_INSTR, IF_PC=0, IF_PC_PLUS4=0, ERR_PC=0, skid buffer empty, IMEM_REQ=0.
REQ-029 Reset asserted mid-transaction SHALL abandon any outstanding request; memory responses arriving after reset deassertion while in IDLE/REQ are ignored.

Verification
REQ-030 Reset release, GNT=1, RVALID 1 cycle after grant, RDATA=0x00500093 -> IF_VALID=1, IF_IR=0x00500093, IF_PC=0, IF_PC_PLUS4=4; next request IMEM_ADDR=4.
REQ-031 STALL=1 with IF_VALID=1 while next response (addr 4, RDATA=0xAAAA0013) arrives -> state HOLD, IMEM_REQ=0, IF_PC held at 0; STALL=0 -> IF_PC=4, IF_IR=0xAAAA0013, IMEM_REQ=1 at addr 8.
REQ-032 PC_SOURCE=3, JAL=0x00000100 in WAIT with RVALID 2 cycles later -> IF_VALID=0, response dropped, next IMEM_ADDR=0x100, first delivered IF_PC=0x100.
REQ-033 PC_SOURCE=2 in the same cycle as grant of addr 0x20, BRANCH=0x40 -> DROP, 0x20 data discarded, next IMEM_ADDR=0x40.
REQ-034 PC_SOURCE=1, JALR=0x00000207 -> ERR_PC pulses 1 cycle, next IMEM_ADDR=0x204.
REQ-035 PC=0xFFFFFFFC granted -> IF_PC=0xFFFFFFFC, IF_PC_PLUS4=0, next IMEM_ADDR=0.
